// File: rtl/cdc_handshake_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_receiver
// Description : Destination-side responder of a two-phase (toggle) req/ack
//               clock-domain-crossing handshake. Synchronizes the incoming
//               request toggle, captures the source-held data word, offers
//               it on a valid/ready interface and returns an ack toggle once
//               the word has been consumed.
// Ports       : dest_clk    - destination clock, rising edge
//               reset       - synchronous active-high reset
//               req_async   - request toggle from the source domain
//               data_async  - source data, stable while a request is open
//               ack_out     - acknowledge toggle level back to the source
//               out_valid   - captured word available
//               out_data    - captured word
//               out_ready   - consumer accepts word when high with out_valid
//               xfer_count  - completed transfers (wrapping 16-bit counter)
//               proto_err   - sticky: source toggled req before seeing ack
// Parameters  : DATA_W      - data word width
//               SYNC_STAGES - synchronizer depth on req_async (2..4)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              dest_clk,
    input  logic              reset,
    input  logic              req_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [15:0]       xfer_count,
    output logic              proto_err
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_VALID = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [0:0]             r_state;
    logic                   r_ack;
    logic                   r_valid;
    logic [DATA_W-1:0]      r_data;
    logic [15:0]            r_count;
    logic                   r_err;

    logic w_req_sync;
    logic w_pending;
    logic w_err_now;

    // Request synchronizer: only the last stage is ever looked at.
    always_ff @(posedge dest_clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_async};
        end
    end

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_pending  = (w_req_sync != r_ack);

    // While a word is held, the request can only match ack again if the
    // source toggled a second time without waiting for our acknowledge.
    assign w_err_now  = (r_state == c_ST_VALID) && !w_pending;

    always_ff @(posedge dest_clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_err_now) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pending) begin
                        r_data  <= data_async;
                        r_valid <= 1'b1;
                        r_state <= c_ST_VALID;
                    end
                end
                c_ST_VALID: begin
                    if (out_ready) begin
                        r_ack   <= ~r_ack;
                        r_count <= r_count + 16'd1;
                        r_valid <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out    = r_ack;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign xfer_count = r_count;
    // The live term makes the flag visible as soon as the synchronized
    // request reveals the violation; the sticky register keeps it until reset.
    assign proto_err  = r_err | w_err_now;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_receiver
// Description : Directed self-checking bench for cdc_handshake_receiver
//               (DATA_W=8, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_receiver;

    logic        dest_clk;
    logic        reset;
    logic        req_async;
    logic [7:0]  data_async;
    logic        ack_out;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] xfer_count;
    logic        proto_err;

    int n_checks;
    int n_fail;

    cdc_handshake_receiver #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .dest_clk   (dest_clk),
        .reset      (reset),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_out    (ack_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .xfer_count (xfer_count),
        .proto_err  (proto_err)
    );

    initial dest_clk = 1'b0;
    always #5 dest_clk = ~dest_clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick;
        @(posedge dest_clk);
        #1;
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        req_async  = 1'b0;
        data_async = 8'h00;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        req_async  = 1'b0;
        data_async = 8'h00;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if ({ack_out, out_valid, out_data, xfer_count, proto_err} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: ack=%0b valid=%0b data=%h cnt=%0d err=%0b, required all 0",
                     ack_out, out_valid, out_data, xfer_count, proto_err);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_valid: cycle %0d valid=%0b, required 0", i, out_valid);
            end
        end
        n_checks++;
        if ({ack_out, out_data, xfer_count, proto_err} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: ack=%0b data=%h cnt=%0d err=%0b, required all 0",
                     ack_out, out_data, xfer_count, proto_err);
        end
    endtask

    task automatic test_single;
        apply_reset();
        out_ready  = 1'b1;
        data_async = 8'hA5;
        req_async  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid: valid=%0b after edge 2, required 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_capture: valid=%0b data=%h, required 1 a5", out_valid, out_data);
        end
        tick();
        n_checks++;
        if (ack_out !== 1'b1 || out_valid !== 1'b0 || xfer_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_ack: ack=%0b valid=%0b cnt=%0d, required 1 0 1",
                     ack_out, out_valid, xfer_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || ack_out !== 1'b1) begin
                n_fail++;
                $display("FAIL single_no_recapture: valid=%0b ack=%0b, required 0 1", out_valid, ack_out);
            end
        end
    endtask

    // Continues from test_single: ack_out=1, req_async=1, xfer_count=1.
    task automatic test_backpressure;
        out_ready  = 1'b0;
        data_async = 8'h3C;
        req_async  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_capture: valid=%0b data=%h, required 1 3c", out_valid, out_data);
        end
        data_async = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_out !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%0b data=%h ack=%0b, required 1 3c 1",
                         i, out_valid, out_data, ack_out);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (ack_out !== 1'b0 || out_valid !== 1'b0 || xfer_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_release: ack=%0b valid=%0b cnt=%0d, required 0 0 2",
                     ack_out, out_valid, xfer_count);
        end
    endtask

    task automatic test_stream;
        logic src_req;
        logic s1;
        logic s2;
        logic prev_ack;
        int   sent;
        int   got;
        int   toggles;
        int   cyc;
        apply_reset();
        src_req  = 1'b0;
        s1       = 1'b0;
        s2       = 1'b0;
        prev_ack = ack_out;
        sent     = 0;
        got      = 0;
        toggles  = 0;
        cyc      = 0;
        while (!(got == 4 && sent == 4 && s2 == src_req) && cyc < 400) begin
            if (s2 == src_req && sent < 4) begin
                sent       = sent + 1;
                data_async = 8'(sent);
                src_req    = ~src_req;
                req_async  = src_req;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                got = got + 1;
                n_checks++;
                if (out_data !== 8'(got)) begin
                    n_fail++;
                    $display("FAIL stream_order: word %0d data=%h, required %h", got, out_data, 8'(got));
                end
            end
            tick();
            cyc = cyc + 1;
            if (ack_out !== prev_ack) toggles = toggles + 1;
            prev_ack = ack_out;
            s2 = s1;
            s1 = ack_out;
        end
        n_checks++;
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL stream_timeout: got=%0d sent=%0d, required 4 4", got, sent);
        end
        n_checks++;
        if (got !== 4 || toggles !== 4) begin
            n_fail++;
            $display("FAIL stream_counts: words=%0d ack_toggles=%0d, required 4 4", got, toggles);
        end
        n_checks++;
        if (xfer_count !== 16'd4 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_status: cnt=%0d err=%0b, required 4 0", xfer_count, proto_err);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_proto_err;
        apply_reset();
        out_ready  = 1'b0;
        data_async = 8'h5A;
        req_async  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (out_valid !== 1'b1 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_setup: valid=%0b err=%0b, required 1 0", out_valid, proto_err);
        end
        req_async = 1'b0;
        tick();
        tick();
        n_checks++;
        if (proto_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL perr_detect: err=%0b valid=%0b data=%h, required 1 1 5a",
                     proto_err, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (proto_err !== 1'b1 || xfer_count !== 16'd1) begin
            n_fail++;
            $display("FAIL perr_sticky: err=%0b cnt=%0d, required 1 1", proto_err, xfer_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clear: err=%0b, required 0", proto_err);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        out_ready  = 1'b1;
        data_async = 8'h11;
        req_async  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready  = 1'b0;
        data_async = 8'h22;
        req_async  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (out_valid !== 1'b1 || ack_out !== 1'b1 || out_data !== 8'h22) begin
            n_fail++;
            $display("FAIL mid_setup: valid=%0b ack=%0b data=%h, required 1 1 22",
                     out_valid, ack_out, out_data);
        end
        reset     = 1'b1;
        req_async = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || ack_out !== 1'b0 || xfer_count !== 16'd0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%0b ack=%0b cnt=%0d data=%h, required 0 0 0 00",
                     out_valid, ack_out, xfer_count, out_data);
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_early: valid=%0b after 2 edges, required 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_fail++;
            $display("FAIL mid_recapture: valid=%0b data=%h, required 1 22", out_valid, out_data);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_async  = 1'b0;
        data_async = 8'h00;
        out_ready  = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_proto_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdc_handshake_receiver.md
# cdc_handshake_receiver

Destination-side responder of the two-phase (toggle) request/acknowledge CDC handshake used to move multi-bit words between the source and destination clock domains. It runs entirely on `dest_clk`. It synchronizes the asynchronous request toggle through a flop chain and captures the source-held data word. It presents the word on a valid/ready interface and returns an acknowledge toggle to the source once the word is consumed.

## Interface
- `DATA_W`, default 8: data word width.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `req_async`; legal range 2..4.
- `dest_clk`  in  1  destination clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_async`  in  1  request toggle from source domain; asynchronous to `dest_clk`.
- `data_async`  in  DATA_W  source data; held stable by source from req toggle until it sees ack toggle.
- `ack_out`  out  1  acknowledge toggle level returned to source; registered.
- `out_valid`  out  1  captured word available.
- `out_data`  out  DATA_W  captured word; registered.
- `out_ready`  in  1  consumer accepts word when high with `out_valid`.
- `xfer_count`  out  16  completed transfers, wraps 0xFFFF -> 0x0000.
- `proto_err`  out  1  sticky flag: source toggled req before ack.

## Operation
- Sync chain: `sync[0]` <= `req_async`, `sync[i]` <= `sync[i-1]`; `req_sync` = `sync[SYNC_STAGES-1]`. Only `req_sync` is used by logic.
- Pending request is defined as `req_sync != ack_out`.
- FSM states are IDLE and VALID.
  - IDLE: on pending request, `out_data` <= `data_async`, `out_valid` <= 1, go to VALID. Otherwise hold.
  - VALID: `out_valid` = 1, `out_data` frozen. On `out_valid && out_ready`: `ack_out` toggles, `xfer_count` += 1, `out_valid` <= 0, go to IDLE.
  - VALID with `req_sync == ack_out` means the source toggled again without waiting for ack. Set `proto_err` <= 1. The current word and FSM are unaffected.
- `out_ready` is ignored in IDLE.
- `data_async` changes after capture do not affect `out_data`.
- After ack, `req_sync == ack_out`, so no re-capture occurs. The next transfer starts only on the next req toggle.
- Reset values: all `sync` flops 0, `ack_out` 0, `out_valid` 0, `out_data` 0, `xfer_count` 0, `proto_err` 0, state IDLE.
- Reset mid-transfer: the word is discarded and outputs return to reset values on the next edge.
  - If `req_async` is 1 after reset release, it is treated as a new pending request.
  - Source and receiver must be reset together.

## Timing
- Edge 1 is the first `dest_clk` edge sampling a new `req_async` level.
- `req_sync` is updated after edge `SYNC_STAGES`.
- Capture occurs on edge `SYNC_STAGES+1`, so `out_valid` is high after that edge. This is 3 edges for the default.
- `ack_out` toggles on the same edge that samples `out_valid && out_ready`; `out_valid` deasserts on that edge. There is no combinational path from `out_ready` to any output.
- With `out_ready` tied high, `out_valid` is high exactly one cycle per transfer.
- At least one IDLE cycle occurs between consecutive `out_valid` pulses.
- Minimum round trip seen by the source is `SYNC_STAGES+2` dest edges plus the source-side ack synchronization.
- `proto_err` sets within `SYNC_STAGES` edges of the offending toggle. It is cleared only by `reset`.

## Test plan
- Reset: hold `reset` 3 cycles with `req_async`=0, then release for 10 cycles. All outputs stay 0 and `out_valid` never asserts.
- Single transfer (`DATA_W`=8, `SYNC_STAGES`=2, `out_ready`=1):
  - Stimulus: `data_async`=0xA5, then `req_async` 0->1 before edge 1.
  - `out_valid`=1 with `out_data`=0xA5 after edge 3.
  - After edge 4: `ack_out`=1, `out_valid`=0, `xfer_count`=1.
- Backpressure:
  - Stimulus: `data_async`=0x3C with req toggle, `out_ready`=0 for 5 cycles, `data_async` changed to 0xFF after capture.
  - During backpressure: `out_valid` held, `out_data` stays 0x3C, `ack_out` unchanged.
  - Raising `out_ready`: `ack_out` toggles on the next edge.
- Stream: a source model with its own 2-flop ack synchronizer sends 0x01, 0x02, 0x03, 0x04 with random `out_ready`. Words are delivered in order, `ack_out` toggles 4 times, `xfer_count`=4, `proto_err`=0.
- Protocol error: toggle `req_async` again while VALID with `out_ready`=0.
  - `proto_err`=1 within 2 edges, and the pending word remains valid.
  - After `reset`, `proto_err`=0.
- Reset mid-transfer: assert `reset` while `out_valid`=1 and `ack_out`=1.
  - Next edge: `out_valid`=0, `ack_out`=0, `xfer_count`=0.
  - With `req_async`=1 held, `out_valid` reasserts 3 edges after release.
